// File: rtl/i2c_target_regbank.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2c_target_regbank
//
// I2C target exposing NREGS 8-bit registers to an external I2C controller.
// The first byte after the target address loads the register pointer. Later
// write bytes land at the pointer, and reads stream from it. The pointer
// auto-increments after each byte and wraps modulo NREGS. The on-chip fabric
// can also write registers through the host port.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   scl, sda_i      raw pad inputs (synchronised internally)
//   sda_oe          1 = pull SDA low, 0 = release (open-drain enable only)
//   host_we/addr/wdata  fabric register write port
//   regs_flat       all register contents, reg k at [8k+7:8k]
//   wr_stb/addr/data    notification of a register committed over I2C
//   busy            high from an address-matched START until STOP
//   dbg_state       current FSM state, for observation only
//
// Handshakes: host_we is a single-cycle strobe with no back-pressure; every
// cycle it is high performs a write. wr_stb is a valid-only pulse with no
// ready; wr_addr/wr_data are meaningful only in the cycle wr_stb is high.
// ----------------------------------------------------------------------------
module i2c_target_regbank #(
    parameter logic [6:0] ADRS        = 7'h50,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    localparam int        PW          = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    input  logic                 sda_i,
    output logic                 sda_oe,
    input  logic                 host_we,
    input  logic [PW-1:0]        host_addr,
    input  logic [7:0]           host_wdata,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_stb,
    output logic [PW-1:0]        wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy,
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT      = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and bus-event detection. Events are registered,
    // so every event pulse lines up with sda_smp, the SDA value seen at
    // the same instant as the SCL edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s;
    logic                   scl_d, sda_d;
    logic                   rise, fall, start_det, stop_det;
    logic                   sda_smp;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            rise      <= 1'b0;
            fall      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_smp   <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d     <= scl_s;
            sda_d     <= sda_s;
            rise      <= scl_s & ~scl_d;
            fall      <= ~scl_s & scl_d;
            start_det <= scl_s & scl_d & sda_d & ~sda_s;
            stop_det  <= scl_s & scl_d & ~sda_d & sda_s;
            sda_smp   <= sda_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM and transfer datapath
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic          rw, rw_nxt;
    // In the *_ACK states: ACK slot is being driven (write side) or the
    // controller ACKed and a reload is pending (read side).
    logic          ack_flag, ack_flag_nxt;
    logic          sda_oe_nxt;
    logic          busy_nxt;
    logic          commit;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic [PW-1:0] ptr_inc;
    logic [7:0]    regs [NREGS];

    assign rx_byte   = {shreg[6:0], sda_smp};
    assign rd_byte   = regs[ptr];
    assign ptr_inc   = ptr + PW'(1);
    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ptr_nxt      = ptr;
        rw_nxt       = rw;
        ack_flag_nxt = ack_flag;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        commit       = 1'b0;

        if (stop_det) begin
            state_nxt    = IDLE;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b0;
            bit_cnt_nxt  = 4'd0;
            ack_flag_nxt = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps ptr and busy; any partial byte is dropped.
            state_nxt    = ADDR;
            sda_oe_nxt   = 1'b0;
            bit_cnt_nxt  = 4'd0;
            ack_flag_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: ;

                ADDR, PTR, WDATA: begin
                    if (rise) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = 4'd0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == ADRS) begin
                                    state_nxt = ADDR_ACK;
                                    busy_nxt  = 1'b1;
                                    rw_nxt    = rx_byte[0];
                                end else begin
                                    state_nxt = WAIT;
                                end
                            end else if (state == PTR) begin
                                ptr_nxt   = rx_byte[PW-1:0];
                                state_nxt = PTR_ACK;
                            end else begin
                                commit    = 1'b1;
                                ptr_nxt   = ptr_inc;
                                state_nxt = WDATA_ACK;
                            end
                        end
                    end
                end

                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // First fall pulls SDA low, second fall ends the ACK slot.
                    if (fall) begin
                        if (!ack_flag) begin
                            sda_oe_nxt   = 1'b1;
                            ack_flag_nxt = 1'b1;
                        end else begin
                            ack_flag_nxt = 1'b0;
                            sda_oe_nxt   = 1'b0;
                            if (state == ADDR_ACK && rw) begin
                                // Read: first data bit goes out on this same fall.
                                state_nxt  = RDATA;
                                shreg_nxt  = {rd_byte[6:0], 1'b0};
                                sda_oe_nxt = ~rd_byte[7];
                            end else if (state == ADDR_ACK) begin
                                state_nxt = PTR;
                            end else begin
                                state_nxt = WDATA;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nxt   = 1'b0;
                            bit_cnt_nxt  = 4'd0;
                            ack_flag_nxt = 1'b0;
                            state_nxt    = RDATA_ACK;
                        end else begin
                            sda_oe_nxt = ~shreg[7];
                            shreg_nxt  = {shreg[6:0], 1'b0};
                        end
                    end
                end

                RDATA_ACK: begin
                    if (rise) begin
                        ptr_nxt = ptr_inc;
                        if (!sda_smp) begin
                            ack_flag_nxt = 1'b1;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else if (fall && ack_flag) begin
                        // ptr already advanced on the ACK rise.
                        ack_flag_nxt = 1'b0;
                        bit_cnt_nxt  = 4'd0;
                        shreg_nxt    = {rd_byte[6:0], 1'b0};
                        sda_oe_nxt   = ~rd_byte[7];
                        state_nxt    = RDATA;
                    end
                end

                WAIT: sda_oe_nxt = 1'b0;

                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            ptr      <= '0;
            rw       <= 1'b0;
            ack_flag <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            ptr      <= ptr_nxt;
            rw       <= rw_nxt;
            ack_flag <= ack_flag_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            wr_stb   <= commit;
            if (commit) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank. The host write is applied last so it wins a
    // same-address collision with an I2C commit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (commit) begin
                regs[ptr] <= rx_byte;
            end
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs[k];
    end

endmodule

// File: doc/i2c_target_regbank.md
# i2c_target_regbank

I2C target (slave) exposing a parametrised bank of 8-bit registers to an external I2C controller over SDA/SCL, with a register pointer that auto-increments and wraps. It succeeds the single-byte I2C slave: it adds an input synchroniser, repeated-START handling, a pointer/sub-address phase, multi-byte burst reads and writes, and a fabric-side write port. The block sits between the pad-level open-drain buffer, where it drives the output-enable only, and the on-chip logic that consumes register contents.

## Interface
- `ADRS`, 7'h50, 7-bit target address.
- `NREGS`, 16, register count; power of 2, 2..256; `PW = $clog2(NREGS)`.
- `SYNC_STAGES`, 2, flip-flops in each SCL/SDA synchroniser, ≥2.
- `RESET_VAL`, 8'h00, reset value of every register.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `scl`  in  1  SCL from pad.
- `sda_i`  in  1  SDA from pad.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `host_we`  in  1  fabric register write strobe.
- `host_addr`  in  PW  fabric write address.
- `host_wdata`  in  8  fabric write data.
- `regs_flat`  out  8*NREGS  register contents; reg k at [8k+7:8k].
- `wr_stb`  out  1  one-cycle pulse when an I2C write commits a register.
- `wr_addr`  out  PW  register written (valid with `wr_stb`).
- `wr_data`  out  8  byte written (valid with `wr_stb`).
- `busy`  out  1  high from an address-matched START until STOP.

## Operation
- The synchronised `scl_s`/`sda_s` feed one delay register each. From those: `rise` = scl 0→1, `fall` = scl 1→0, START = sda 1→0 with scl high, STOP = sda 0→1 with scl high.
- SDA is sampled on `rise`. SDA changes (`sda_oe` updates) only on `fall`.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- IDLE: START -> ADDR.
- ADDR: shift 8 bits, MSB first. After the 8th `rise`:
  - If `[7:1]==ADRS`, go to ADDR_ACK and set `busy`.
  - Otherwise go to WAIT; no ACK is driven.
- ADDR_ACK: drive low on the next `fall`; release on the following `fall`.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA. The shifter loads `reg[ptr]` at that release `fall`, and its MSB is driven on the same `fall`.
- PTR: 8 bits; `ptr <= byte[PW-1:0]`; upper bits are ignored. ACK -> WDATA.
- WDATA: on the 8th `rise`, `reg[ptr] <= byte`, pulse `wr_stb` with the pre-increment `ptr`, then `ptr <= ptr+1` mod NREGS. ACK -> WDATA.
- RDATA: release on `fall` for 1 bits, drive low for 0 bits. After the 8th bit, release and go to RDATA_ACK.
- RDATA_ACK: sample on `rise`.
  - ACK (0): `ptr++` mod NREGS, reload from the new `ptr` at the next `fall`, go to RDATA.
  - NACK (1): `ptr++`, go to WAIT.
- WAIT: `sda_oe=0`; wait for START or STOP.
- START in any state: abort, discard the partial byte, go to ADDR. `ptr` and `busy` are kept (repeated START).
- STOP in any state: go to IDLE, `sda_oe=0`, `busy=0`. `ptr` is kept.
- A host write and an I2C commit to the same address in the same cycle: host write wins, and `wr_stb` still pulses. Different addresses in the same cycle: both write.

## Timing
- Reset values: `sda_oe=0`, `busy=0`, `wr_stb=0`, `wr_addr=0`, `wr_data=0`, `ptr=0`, state IDLE, every register `RESET_VAL`. Synchroniser flops reset to 1.
- Pin-to-detect latency: SYNC_STAGES+1 cycles. `sda_oe` changes SYNC_STAGES+2 cycles after the SCL pin falls.
- `wr_stb` asserts SYNC_STAGES+2 cycles after the 8th data SCL pin rise. `regs_flat` shows the new value in that same cycle.
- `host_we` updates `regs_flat` in the next cycle.
- Required SCL high and low time: ≥ SYNC_STAGES+4 clk periods each. SDA setup to SCL rise: ≥ 2 clk.
- Reset asserted mid-transfer: SDA is released the next cycle and the state returns to IDLE. Nothing more is driven until a new START.

## Test plan
- Write burst: START, 0xA0, ACK; ptr 0x03, ACK; 0x11, 0x22; STOP. Required: reg3=0x11, reg4=0x22, two `wr_stb` pulses with `wr_addr` 3 then 4, `busy` low after STOP.
- Read with repeated START: write ptr 0x03, Sr, 0xA1; controller ACKs byte 1 and NACKs byte 2. Required: SDA carries 0x11 then 0x22, released after the NACK, `ptr=5`.
- Wrap: NREGS=16, ptr 0x0F, write 0xAA, 0xBB. Required: reg15=0xAA, reg0=0xBB, `wr_addr` 15 then 0.
- Address mismatch: START, 0xA2, one byte, STOP. Required: `sda_oe` stays 0 throughout, no `wr_stb`, `busy` stays 0.
- Collision and abort:
  - `host_we` to reg5 with 0x77 in the same cycle as an I2C commit of 0x55 to reg5. Required: reg5=0x77.
  - START after 4 data bits. Required: partial byte discarded, no `wr_stb`.
- Reset mid-read while driving 0. Required: `sda_oe=0` the next cycle and all registers return to `RESET_VAL`.
